// File: rtl/rv32i_pipeline_top.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : rv32i_pipeline_top (with rv32i_imem, rv32i_fetch)
//  Purpose  : 5-stage in-order RV32I-subset pipeline (IF/ID/EX/MEM/WB) with
//             EX-stage forwarding, load-use stall and EX-resolved branches.
//  Ports    : clk - sole clock, all state updates on the rising edge
//             rst - synchronous active-high reset
//  Revision : 1.0 - initial release
// ============================================================================

// Instruction memory: combinational word read, no write port. Contents are
// loaded externally through mem[].
module rv32i_imem #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic [AW-1:0] addr,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH] = '{default: 32'h0};
  assign rdata = mem[addr];
endmodule

// Fetch stage: word index from PC; the index width wraps fetches past DEPTH.
module rv32i_fetch #(
  parameter int IMEM_DEPTH = 1024
) (
  input  logic [31:0] pc,
  output logic [31:0] instr
);
  localparam int AW = $clog2(IMEM_DEPTH);
  logic unused_pc;
  assign unused_pc = ^{pc[31:AW+2], pc[1:0]};

  rv32i_imem #(.DEPTH(IMEM_DEPTH)) IMEM (
    .addr  (pc[AW+1:2]),
    .rdata (instr)
  );
endmodule

module rv32i_pipeline_top #(
  parameter int          IMEM_DEPTH = 1024,
  parameter int          DMEM_DEPTH = 1024,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic clk,
  input  logic rst
);
  localparam int DAW = $clog2(DMEM_DEPTH);

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_PASSB
  } alu_op_t;

  // ---------------------------------------------------------------- state
  logic [31:0] pc;
  logic [31:0] regs [32];
  logic [31:0] dmem [DMEM_DEPTH] = '{default: 32'h0};

  logic [31:0] ifid_pc, ifid_instr;

  logic [31:0] idex_pc, idex_a, idex_b, idex_imm;
  logic [4:0]  idex_rs1, idex_rs2, idex_rd;
  logic        idex_we, idex_mr, idex_mw, idex_br, idex_bne, idex_use_imm;
  alu_op_t     idex_op;

  logic [31:0] exmem_alu, exmem_sdata;
  logic [4:0]  exmem_rd;
  logic        exmem_we, exmem_mr, exmem_mw;

  logic [31:0] memwb_data;
  logic [4:0]  memwb_rd;
  logic        memwb_we;

  // ---------------------------------------------------------------- IF
  logic [31:0] if_instr;
  rv32i_fetch #(.IMEM_DEPTH(IMEM_DEPTH)) fetch (
    .pc    (pc),
    .instr (if_instr)
  );

  // ---------------------------------------------------------------- ID
  logic [6:0]  opcode, f7;
  logic [2:0]  f3;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm_i, imm_s, imm_b, imm_u;

  assign opcode = ifid_instr[6:0];
  assign rd     = ifid_instr[11:7];
  assign f3     = ifid_instr[14:12];
  assign rs1    = ifid_instr[19:15];
  assign rs2    = ifid_instr[24:20];
  assign f7     = ifid_instr[31:25];
  assign imm_i  = {{20{ifid_instr[31]}}, ifid_instr[31:20]};
  assign imm_s  = {{20{ifid_instr[31]}}, ifid_instr[31:25], ifid_instr[11:7]};
  assign imm_b  = {{19{ifid_instr[31]}}, ifid_instr[31], ifid_instr[7],
                   ifid_instr[30:25], ifid_instr[11:8], 1'b0};
  assign imm_u  = {ifid_instr[31:12], 12'h000};

  logic        d_we, d_mr, d_mw, d_br, d_bne, d_use_imm, d_use1, d_use2;
  logic [31:0] d_imm;
  alu_op_t     d_op;

  // Unrecognised encodings leave every control bit at its default, so they
  // flow down the pipe as harmless NOPs.
  always_comb begin
    d_we = 1'b0; d_mr = 1'b0; d_mw = 1'b0; d_br = 1'b0; d_bne = 1'b0;
    d_use_imm = 1'b0; d_use1 = 1'b0; d_use2 = 1'b0;
    d_imm = imm_i; d_op = ALU_ADD;
    case (opcode)
      7'b0110011: begin
        d_use_imm = 1'b0;
        case ({f7, f3})
          {7'h00, 3'd0}: begin d_op = ALU_ADD;  d_we = 1'b1; end
          {7'h20, 3'd0}: begin d_op = ALU_SUB;  d_we = 1'b1; end
          {7'h00, 3'd1}: begin d_op = ALU_SLL;  d_we = 1'b1; end
          {7'h00, 3'd2}: begin d_op = ALU_SLT;  d_we = 1'b1; end
          {7'h00, 3'd3}: begin d_op = ALU_SLTU; d_we = 1'b1; end
          {7'h00, 3'd4}: begin d_op = ALU_XOR;  d_we = 1'b1; end
          {7'h00, 3'd5}: begin d_op = ALU_SRL;  d_we = 1'b1; end
          {7'h20, 3'd5}: begin d_op = ALU_SRA;  d_we = 1'b1; end
          {7'h00, 3'd6}: begin d_op = ALU_OR;   d_we = 1'b1; end
          {7'h00, 3'd7}: begin d_op = ALU_AND;  d_we = 1'b1; end
          default: ;
        endcase
        d_use1 = d_we;
        d_use2 = d_we;
      end
      7'b0010011: begin
        d_use_imm = 1'b1;
        case (f3)
          3'd0: begin d_op = ALU_ADD;  d_we = 1'b1; end
          3'd2: begin d_op = ALU_SLT;  d_we = 1'b1; end
          3'd3: begin d_op = ALU_SLTU; d_we = 1'b1; end
          3'd4: begin d_op = ALU_XOR;  d_we = 1'b1; end
          3'd6: begin d_op = ALU_OR;   d_we = 1'b1; end
          3'd7: begin d_op = ALU_AND;  d_we = 1'b1; end
          3'd1: if (f7 == 7'h00) begin d_op = ALU_SLL; d_we = 1'b1; end
          3'd5: begin
            if (f7 == 7'h00)      begin d_op = ALU_SRL; d_we = 1'b1; end
            else if (f7 == 7'h20) begin d_op = ALU_SRA; d_we = 1'b1; end
          end
          default: ;
        endcase
        d_use1 = d_we;
      end
      7'b0000011: if (f3 == 3'd2) begin
        d_we = 1'b1; d_mr = 1'b1; d_use_imm = 1'b1; d_use1 = 1'b1;
      end
      7'b0100011: if (f3 == 3'd2) begin
        d_mw = 1'b1; d_use_imm = 1'b1; d_use1 = 1'b1; d_use2 = 1'b1;
        d_imm = imm_s;
      end
      7'b1100011: if (f3 == 3'd0 || f3 == 3'd1) begin
        d_br = 1'b1; d_bne = f3[0]; d_use1 = 1'b1; d_use2 = 1'b1;
        d_imm = imm_b;
      end
      7'b0110111: begin
        d_we = 1'b1; d_use_imm = 1'b1; d_imm = imm_u; d_op = ALU_PASSB;
      end
      default: ;
    endcase
  end

  // Register read with write-through from the WB stage.
  logic [31:0] rf_a, rf_b;
  always_comb begin
    rf_a = regs[rs1];
    rf_b = regs[rs2];
    if (memwb_we && memwb_rd != 5'd0 && memwb_rd == rs1) rf_a = memwb_data;
    if (memwb_we && memwb_rd != 5'd0 && memwb_rd == rs2) rf_b = memwb_data;
    if (rs1 == 5'd0) rf_a = 32'h0;
    if (rs2 == 5'd0) rf_b = 32'h0;
  end

  // A load in EX cannot forward to the instruction now in ID: hold one cycle.
  logic load_use;
  assign load_use = idex_mr && idex_rd != 5'd0 &&
                    ((d_use1 && rs1 == idex_rd) || (d_use2 && rs2 == idex_rd));

  // ---------------------------------------------------------------- EX
  logic [31:0] fwd_a, fwd_b, op_b, alu_y, br_target;
  logic        taken;

  always_comb begin
    fwd_a = idex_a;
    if (exmem_we && exmem_rd != 5'd0 && exmem_rd == idex_rs1)      fwd_a = exmem_alu;
    else if (memwb_we && memwb_rd != 5'd0 && memwb_rd == idex_rs1) fwd_a = memwb_data;
    fwd_b = idex_b;
    if (exmem_we && exmem_rd != 5'd0 && exmem_rd == idex_rs2)      fwd_b = exmem_alu;
    else if (memwb_we && memwb_rd != 5'd0 && memwb_rd == idex_rs2) fwd_b = memwb_data;
  end

  assign op_b = idex_use_imm ? idex_imm : fwd_b;

  always_comb begin
    alu_y = 32'h0;
    case (idex_op)
      ALU_ADD:   alu_y = fwd_a + op_b;
      ALU_SUB:   alu_y = fwd_a - op_b;
      ALU_AND:   alu_y = fwd_a & op_b;
      ALU_OR:    alu_y = fwd_a | op_b;
      ALU_XOR:   alu_y = fwd_a ^ op_b;
      ALU_SLT:   alu_y = {31'h0, $signed(fwd_a) < $signed(op_b)};
      ALU_SLTU:  alu_y = {31'h0, fwd_a < op_b};
      ALU_SLL:   alu_y = fwd_a << op_b[4:0];
      ALU_SRL:   alu_y = fwd_a >> op_b[4:0];
      ALU_SRA:   alu_y = $unsigned($signed(fwd_a) >>> op_b[4:0]);
      ALU_PASSB: alu_y = op_b;
      default:   alu_y = 32'h0;
    endcase
  end

  assign taken     = idex_br && ((fwd_a == fwd_b) ^ idex_bne);
  assign br_target = idex_pc + idex_imm;

  // ---------------------------------------------------------------- MEM
  logic [31:0] dmem_rdata;
  assign dmem_rdata = dmem[exmem_alu[DAW+1:2]];

  always_ff @(posedge clk) begin
    if (!rst && exmem_mw) dmem[exmem_alu[DAW+1:2]] <= exmem_sdata;
  end

  // ---------------------------------------------------------------- pipeline registers
  always_ff @(posedge clk) begin
    if (rst)            pc <= RESET_PC;
    else if (taken)     pc <= br_target;
    else if (!load_use) pc <= pc + 32'd4;
  end

  // A zero instruction word decodes as a NOP, so it doubles as the bubble.
  always_ff @(posedge clk) begin
    if (rst || taken) begin
      ifid_pc    <= 32'h0;
      ifid_instr <= 32'h0;
    end else if (!load_use) begin
      ifid_pc    <= pc;
      ifid_instr <= if_instr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || taken || load_use) begin
      idex_pc <= 32'h0; idex_a <= 32'h0; idex_b <= 32'h0; idex_imm <= 32'h0;
      idex_rs1 <= 5'd0; idex_rs2 <= 5'd0; idex_rd <= 5'd0;
      idex_we <= 1'b0; idex_mr <= 1'b0; idex_mw <= 1'b0;
      idex_br <= 1'b0; idex_bne <= 1'b0; idex_use_imm <= 1'b0;
      idex_op <= ALU_ADD;
    end else begin
      idex_pc <= ifid_pc; idex_a <= rf_a; idex_b <= rf_b; idex_imm <= d_imm;
      idex_rs1 <= rs1; idex_rs2 <= rs2; idex_rd <= rd;
      idex_we <= d_we; idex_mr <= d_mr; idex_mw <= d_mw;
      idex_br <= d_br; idex_bne <= d_bne; idex_use_imm <= d_use_imm;
      idex_op <= d_op;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exmem_alu <= 32'h0; exmem_sdata <= 32'h0; exmem_rd <= 5'd0;
      exmem_we <= 1'b0; exmem_mr <= 1'b0; exmem_mw <= 1'b0;
    end else begin
      exmem_alu <= alu_y; exmem_sdata <= fwd_b; exmem_rd <= idex_rd;
      exmem_we <= idex_we; exmem_mr <= idex_mr; exmem_mw <= idex_mw;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      memwb_data <= 32'h0; memwb_rd <= 5'd0; memwb_we <= 1'b0;
    end else begin
      memwb_data <= exmem_mr ? dmem_rdata : exmem_alu;
      memwb_rd   <= exmem_rd;
      memwb_we   <= exmem_we;
    end
  end

  // ---------------------------------------------------------------- WB
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
    end else if (memwb_we && memwb_rd != 5'd0) begin
      regs[memwb_rd] <= memwb_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rv32i_pipeline_top.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_rv32i_pipeline_top
//  Purpose  : Directed programs loaded into instruction memory; register file,
//             data memory and PC compared against hand-computed values.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rv32i_pipeline_top;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rv32i_pipeline_top dut (
    .clk (clk),
    .rst (rst)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Advance n rising edges and return sampling on the following falling edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load(input logic [31:0] prog[$]);
    for (int i = 0; i < 1024; i++) dut.fetch.IMEM.mem[i] = 32'h0;
    for (int i = 0; i < prog.size(); i++) dut.fetch.IMEM.mem[i] = prog[i];
  endtask

  // Leaves the bench on a falling edge in the first post-reset cycle.
  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  logic [31:0] prog_alu[$] = '{32'h0FF00493, 32'h0AA00513, 32'h00A485B3,
                               32'h00500813, 32'hFFB58593};
  logic [31:0] acc;

  initial begin
    @(negedge clk);

    // 1: empty memory, PC just counts
    load('{});
    do_reset();
    check("t1_pc_reset", dut.pc, 32'h0);
    tick(5);
    check("t1_pc_adv", dut.pc, 32'd20);
    acc = 32'h0;
    for (int i = 0; i < 32; i++) acc |= dut.regs[i];
    check("t1_regs_zero", acc, 32'h0);
    check("t1_dmem2", dut.dmem[2], 32'h0);

    // 2: forwarding chain
    load(prog_alu);
    do_reset();
    tick(4);
    check("t2_x9_early", dut.regs[9], 32'h0);
    tick(1);
    check("t2_x9_latency", dut.regs[9], 32'd255);
    tick(7);
    check("t2_x9",  dut.regs[9],  32'd255);
    check("t2_x10", dut.regs[10], 32'd170);
    check("t2_x16", dut.regs[16], 32'd5);
    check("t2_x11", dut.regs[11], 32'h1A4);

    // 3: R-type / I-type ALU operations
    load('{32'h00400093, 32'h00700113, 32'h40208233, 32'h0020F2B3,
           32'h0020E333, 32'h0020C3B3, 32'h0020A433,
           32'hFFF00093, 32'h00100113, 32'h0020B4B3, 32'h0020A533,
           32'h4020D5B3, 32'h0020D633, 32'h002096B3, 32'h0040D713,
           32'h0F00C793});
    do_reset();
    tick(22);
    check("t3_sub",  dut.regs[4],  32'hFFFFFFFD);
    check("t3_and",  dut.regs[5],  32'd4);
    check("t3_or",   dut.regs[6],  32'd7);
    check("t3_xor",  dut.regs[7],  32'd3);
    check("t3_slt",  dut.regs[8],  32'd1);
    check("t3_sltu", dut.regs[9],  32'd0);
    check("t3_slt_neg", dut.regs[10], 32'd1);
    check("t3_sra",  dut.regs[11], 32'hFFFFFFFF);
    check("t3_srl",  dut.regs[12], 32'h7FFFFFFF);
    check("t3_sll",  dut.regs[13], 32'hFFFFFFFE);
    check("t3_srli", dut.regs[14], 32'h0FFFFFFF);
    check("t3_xori", dut.regs[15], 32'hFFFFFF0F);

    // 4: store, load, load-use dependent add (one stall cycle)
    load('{32'h00D00193, 32'h00302423, 32'h00802283, 32'h00528333});
    do_reset();
    tick(8);
    check("t4_x6_stalled", dut.regs[6], 32'h0);
    tick(1);
    check("t4_x6", dut.regs[6], 32'd26);
    check("t4_x5", dut.regs[5], 32'd13);
    check("t4_dmem2", dut.dmem[2], 32'd13);

    // 5: taken beq flushes two slots, not-taken bne falls through
    load('{32'h00000463, 32'h00100393, 32'h00240413, 32'h00001463,
           32'h00300493});
    do_reset();
    tick(7);
    check("t5_x8_penalty", dut.regs[8], 32'h0);
    tick(1);
    check("t5_x8_arrive", dut.regs[8], 32'd2);
    tick(6);
    check("t5_x7_flushed", dut.regs[7], 32'h0);
    check("t5_x8", dut.regs[8], 32'd2);
    check("t5_x9_bne", dut.regs[9], 32'd3);

    // 6: reset mid-program kills in-flight writes, program reruns
    load(prog_alu);
    do_reset();
    tick(5);
    check("t6_x9_pre", dut.regs[9], 32'd255);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("t6_pc_reset", dut.pc, 32'h0);
    check("t6_x9_reset", dut.regs[9], 32'h0);
    tick(4);
    check("t6_x10_killed", dut.regs[10], 32'h0);
    check("t6_x9_not_yet", dut.regs[9], 32'h0);
    tick(8);
    check("t6_x9",  dut.regs[9],  32'd255);
    check("t6_x10", dut.regs[10], 32'd170);
    check("t6_x16", dut.regs[16], 32'd5);
    check("t6_x11", dut.regs[11], 32'h1A4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
